// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: RAM command codes and FSM states.
package ram_arb_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The priority pointer moves to the other requester
// each time a grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Granting requester 0 hands priority to requester 1, and vice versa.
    assign prio_d = accept_i ? gnt_o[0] : prio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one command-driven RAM between two requesters, serialising each
// transaction into command words and caching the RAM's address pointers.
//
// state | meaning
// IDLE  | waiting for a request, req_ready follows the arbiter grant
// ADDR  | issuing a pointer-load command (cache miss)
// DATA  | issuing the write-data or read command
// WAIT  | waiting for RAM read data, bounded by RD_TIMEOUT
// RESP  | one-cycle response pulse to the originating requester
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0]             req_wr_i,
    input  logic [2*ADDR_SIZE-1:0] req_addr_i,
    input  logic [2*ADDR_SIZE-1:0] req_wdata_i,
    output logic [1:0]             rsp_valid_o,
    output logic [ADDR_SIZE-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [ADDR_SIZE+1:0]   ram_din_o,
    output logic                   ram_rx_valid_o,
    input  logic [ADDR_SIZE-1:0]   ram_dout_i,
    input  logic                   ram_tx_valid_i
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(RD_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic                   id_q, id_d;
    logic                   wr_q, wr_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
    logic [ADDR_SIZE-1:0]   wa_q, wa_d;
    logic [ADDR_SIZE-1:0]   ra_q, ra_d;
    logic                   wa_ok_q, wa_ok_d;
    logic                   ra_ok_q, ra_ok_d;
    logic [ADDR_SIZE-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [TW-1:0]          cnt_q, cnt_d;

    logic [1:0]             gnt;
    logic                   accept;
    logic                   sel;
    logic                   sel_wr;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [ADDR_SIZE-1:0]   sel_wdata;
    logic                   hit;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_valid_i),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign accept      = (state_q == IDLE) && (gnt != 2'b00);
    assign req_ready_o = ((state_q == IDLE) && rst_n) ? gnt : 2'b00;

    assign sel       = gnt[1];
    assign sel_wr    = sel ? req_wr_i[1] : req_wr_i[0];
    assign sel_addr  = sel ? req_addr_i[2*ADDR_SIZE-1:ADDR_SIZE]  : req_addr_i[ADDR_SIZE-1:0];
    assign sel_wdata = sel ? req_wdata_i[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata_i[ADDR_SIZE-1:0];
    assign hit       = sel_wr ? (wa_ok_q && (wa_q == sel_addr)) : (ra_ok_q && (ra_q == sel_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = hit ? DATA : ADDR;
            ADDR: state_d = DATA;
            DATA: state_d = wr_q ? IDLE : WAIT;
            WAIT: if (ram_tx_valid_i || (cnt_q == '0)) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_rx_valid_o = 1'b0;
        ram_din_o      = '0;
        rsp_valid_o    = 2'b00;
        case (state_q)
            ADDR: begin
                ram_rx_valid_o = 1'b1;
                ram_din_o      = {wr_q ? CMD_WR_ADDR : CMD_RD_ADDR, addr_q};
            end
            DATA: begin
                ram_rx_valid_o = 1'b1;
                ram_din_o      = wr_q ? {CMD_WR_DATA, wdata_q} : {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
            end
            RESP: rsp_valid_o = id_q ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        id_d    = id_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wa_d    = wa_q;
        ra_d    = ra_q;
        wa_ok_d = wa_ok_q;
        ra_ok_d = ra_ok_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                id_d    = sel;
                wr_d    = sel_wr;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
            end
            ADDR: if (wr_q) begin
                wa_d    = addr_q;
                wa_ok_d = 1'b1;
            end else begin
                ra_d    = addr_q;
                ra_ok_d = 1'b1;
            end
            DATA: cnt_d = TO_LOAD;
            WAIT: if (ram_tx_valid_i) begin
                rdata_d = ram_dout_i;
                err_d   = 1'b0;
            end else if (cnt_q == '0) begin
                // A silent RAM may have lost its pointers too, so force reloads.
                rdata_d = '0;
                err_d   = 1'b1;
                wa_ok_d = 1'b0;
                ra_ok_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wa_q    <= '0;
            ra_q    <= '0;
            wa_ok_q <= 1'b0;
            ra_ok_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            id_q    <= id_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wa_q    <= wa_d;
            ra_q    <= ra_d;
            wa_ok_q <= wa_ok_d;
            ra_ok_q <= ra_ok_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port front-end that shares the single-port command-driven RAM between two requesters (e.g. the SPI slave path and a local test/DMA port). It accepts whole read or write transactions on a valid/ready interface, arbitrates round-robin, and serialises each transaction into the RAM's 10-bit command words. It returns read data to the originating requester. It caches the RAM's internal write and read address pointers, so back-to-back accesses to the same address skip the address phase.

## Interface
Parameters:
- ADDR_SIZE, 8, address and data width; RAM command word is ADDR_SIZE+2 bits
- RD_TIMEOUT, 4, number of cycles in WAIT without ram_tx_valid before a read is aborted with error

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low; applies to all state in this block
- req_valid  input  2  per-requester transaction request, bit i = requester i
- req_ready  output  2  per-requester accept; a transaction is taken on an edge where req_valid[i] & req_ready[i]
- req_wr  input  2  1 = write, 0 = read, per requester
- req_addr  input  2*ADDR_SIZE  requester i address in bits [i*ADDR_SIZE +: ADDR_SIZE]
- req_wdata  input  2*ADDR_SIZE  requester i write data, same packing as req_addr
- rsp_valid  output  2  one-cycle pulse, one-hot, marks read completion to requester i
- rsp_rdata  output  ADDR_SIZE  read data, shared by both requesters, qualified by rsp_valid
- rsp_err  output  1  read timed out, qualified by rsp_valid; rsp_rdata is 0 in that case
- ram_din  output  ADDR_SIZE+2  command word {cmd[1:0], payload} to the RAM
- ram_rx_valid  output  1  command strobe to the RAM
- ram_dout  input  ADDR_SIZE  RAM read data
- ram_tx_valid  input  1  RAM read-data-valid (sticky until the RAM's next command)

## Operation
- RAM command codes:
  - 00: load write pointer
  - 01: write data at the write pointer
  - 10: load read pointer
  - 11: read at the read pointer
- FSM states and transitions:
  - IDLE: req_ready asserted for the granted requester only, and only in this state.
  - On accept: latch id, wr, addr and wdata.
    - Go to ADDR if the matching pointer cache misses.
    - Go to DATA if it hits.
  - ADDR: issue {00, addr} for a write or {10, addr} for a read; update the cache with the address and set its valid flag; go to DATA.
  - DATA for a write: issue {01, wdata}; go to IDLE.
  - DATA for a read: issue {11, 0}; go to WAIT.
  - WAIT: capture ram_dout and go to RESP when ram_tx_valid=1.
  - WAIT timeout: after RD_TIMEOUT cycles, set err, capture 0, clear both cache valid flags, go to RESP.
  - RESP: pulse rsp_valid[id] with registered rsp_rdata and rsp_err; go to IDLE.
- Arbitration:
  - Round-robin; after a grant to requester i, requester 1-i has priority when both are valid.
  - A lone valid requester is always granted.
  - After reset, requester 0 has priority.
- Pointer cache:
  - Separate write cache (wa, wa_ok) and read cache (ra, ra_ok).
  - Both ok flags are cleared by reset, because the RAM's internal pointers are not reset.
- ram_rx_valid is 1 only in ADDR and DATA. ram_din holds 0 when ram_rx_valid is 0.

## Timing
- Reset values:
  - req_ready=0 while rst_n is low.
  - ram_rx_valid=0, ram_din=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State IDLE, priority pointer at requester 0, wa_ok=ra_ok=0.
- req_ready is combinational from state and req_valid; it may assert in the first cycle after reset release.
- Cycle numbering: accept handshake is at edge 0; cycle n follows edge n.
  - Write, cache miss: cycle 1 {00,addr}, cycle 2 {01,data}, IDLE in cycle 3.
  - Write, cache hit: {01,data} in cycle 1, IDLE in cycle 2.
  - Read, cache miss: cycle 1 {10,addr}, cycle 2 {11,0}, cycle 3 WAIT (the RAM registers tx_valid at edge 3), cycle 4 rsp_valid, IDLE in cycle 5.
  - Read, cache hit: one cycle earlier than a miss for every step.
- A write does not invalidate the read cache; write and read pointers are independent in the RAM.
- A request that is held while the other requester is served is not dropped. req_* must stay stable until accepted.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; all outputs go to their reset values.
  - No rsp_valid for the aborted transaction.

## Structure
- Package ram_arb_pkg holds:
  - Command constants CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA.
  - The FSM state enum (IDLE, ADDR, DATA, WAIT, RESP).
- One sub-module, rr_arb2: 2-way round-robin grant with a priority register, advanced on accept.

## Test plan
- Reset, then requester 0 writes addr 0x12 data 0xA5 -> {00,0x12} in cycle 1, {01,0xA5} in cycle 2; a write to 0x12 with data 0x5A then issues only {01,0x5A}.
- Read of addr 0x12 after that write -> {10,0x12}, {11,0}; rsp_valid[0] in cycle 4 with rsp_rdata=0x5A, rsp_err=0; a second read of 0x12 skips {10}.
- Both requesters valid continuously -> grants alternate 0,1,0,1; rsp_valid goes only to the reading requester.
- RAM model holds ram_tx_valid=0 after {11} -> rsp_valid with rsp_err=1, rsp_rdata=0 after RD_TIMEOUT cycles; the next access re-issues its address phase.
- rst_n pulsed low during a read's WAIT -> outputs go to 0 asynchronously, no response; the next write re-issues {00,addr}.
- Random mix of reads and writes against a reference memory model -> every rsp_rdata matches; ram_rx_valid is never high outside ADDR or DATA.
